// File: rtl/icache_nway_control.sv
// rtl/icache_nway_control.sv - N-way icache control FSM: tree-PLRU, victim select, line refill, flush
// Optional feature macro: ICACHE_PERF_CNT_EN (32-bit hit/miss performance counters)
module icache_nway_control #(
  parameter int NUM_WAYS  = 4,
  parameter int NUM_SETS  = 16,
  parameter int BURST_LEN = 4,
  localparam int SET_W  = $clog2(NUM_SETS),
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1,
  localparam int WAY_W  = $clog2(NUM_WAYS),
  localparam int PLRU_W = NUM_WAYS - 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic [SET_W-1:0]    set_idx,
  input  logic [NUM_WAYS-1:0] hit_way,
  input  logic [NUM_WAYS-1:0] valid_way,
  input  logic                flush,
  input  logic                pmem_resp,
  output logic                mem_resp,
  output logic                pmem_read,
  output logic                addr_mux_sel,
  output logic [NUM_WAYS-1:0] load_way,
  output logic [BEAT_W-1:0]   beat_idx,
  output logic                valid_in,
  output logic                inval,
  output logic [SET_W-1:0]    inval_set,
  output logic                flush_busy,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);

  typedef enum logic [1:0] {S_CHECK, S_REFILL, S_FLUSH} state_t;

  state_t              r_state, w_state_nxt;
  logic [BEAT_W-1:0]   r_beat;
  logic [SET_W-1:0]    r_fcnt;
  logic [SET_W-1:0]    r_miss_set;
  logic [WAY_W-1:0]    r_victim;
  logic                r_flush_pend;
  logic [PLRU_W-1:0]   r_plru [NUM_SETS];

  logic                w_go_refill;
  logic                w_last_beat;
  logic                w_flush_done;
  logic [WAY_W-1:0]    w_hit_idx;
  logic [WAY_W-1:0]    w_inv_idx;
  logic [WAY_W-1:0]    w_victim;

  // Walk the tree from the root: a 0 bit steers to the lower half, 1 to the upper half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    int n;
    logic [PLRU_W-1:0] bsh;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      bsh = bits >> n;
      n = 2 * n + 1 + int'(bsh[0]);
    end
    return WAY_W'(n - PLRU_W);
  endfunction

  // Point every node on the accessed way's path away from that way.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    int n;
    logic b;
    logic [WAY_W-1:0]  wsh;
    logic [PLRU_W-1:0] r;
    r = bits;
    n = 0;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      wsh = way >> l;
      b = wsh[0];
      r = (r & ~(PLRU_W'(1) << n)) | (PLRU_W'(!b) << n);
      n = 2 * n + 1 + int'(b);
    end
    return r;
  endfunction

  // Encode the one-hot hit vector and find the lowest-index invalid way.
  always_comb begin
    logic [NUM_WAYS-1:0] hsh;
    logic [NUM_WAYS-1:0] vsh;
    w_hit_idx = '0;
    w_inv_idx = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      hsh = hit_way >> i;
      vsh = valid_way >> i;
      if (hsh[0]) w_hit_idx = WAY_W'(i);
      if (!vsh[0]) w_inv_idx = WAY_W'(i);
    end
    w_victim = (~&valid_way) ? w_inv_idx : plru_victim(r_plru[set_idx]);
  end

  // Next-state and output decode.
  always_comb begin
    w_state_nxt  = r_state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    addr_mux_sel = 1'b0;
    load_way     = '0;
    beat_idx     = '0;
    valid_in     = 1'b0;
    inval        = 1'b0;
    inval_set    = '0;
    flush_busy   = 1'b0;
    w_go_refill  = 1'b0;
    w_last_beat  = 1'b0;
    w_flush_done = 1'b0;
    case (r_state)
      S_CHECK: begin
        if (flush || r_flush_pend) begin
          w_state_nxt = S_FLUSH;
        end else if (mem_read && (|hit_way)) begin
          mem_resp = 1'b1;
        end else if (mem_read) begin
          w_state_nxt = S_REFILL;
          w_go_refill = 1'b1;
        end
      end
      S_REFILL: begin
        pmem_read    = 1'b1;
        addr_mux_sel = 1'b1;
        if (pmem_resp) begin
          load_way = NUM_WAYS'(1) << r_victim;
          beat_idx = r_beat;
          if (r_beat == BEAT_W'(BURST_LEN - 1)) begin
            valid_in    = 1'b1;
            w_last_beat = 1'b1;
            w_state_nxt = S_CHECK;
          end
        end
      end
      S_FLUSH: begin
        inval      = 1'b1;
        flush_busy = 1'b1;
        inval_set  = r_fcnt;
        if (r_fcnt == SET_W'(NUM_SETS - 1)) begin
          w_flush_done = 1'b1;
          w_state_nxt  = S_CHECK;
        end
      end
      default: w_state_nxt = S_CHECK;
    endcase
  end

  // FSM state, beat/flush counters, miss latches and pending-flush flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_CHECK;
      r_beat       <= '0;
      r_fcnt       <= '0;
      r_miss_set   <= '0;
      r_victim     <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_go_refill) begin
        r_miss_set <= set_idx;
        r_victim   <= w_victim;
      end
      if (r_state == S_REFILL && pmem_resp)
        r_beat <= w_last_beat ? '0 : r_beat + BEAT_W'(1);
      if (r_state == S_FLUSH)
        r_fcnt <= w_flush_done ? '0 : r_fcnt + SET_W'(1);
      if (r_state == S_REFILL && flush)
        r_flush_pend <= 1'b1;
      else if (w_flush_done)
        r_flush_pend <= 1'b0;
    end
  end

  // Per-set PLRU: touched on hit and on line fill, cleared set-by-set during flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_SETS; s++) r_plru[s] <= '0;
    end else if (mem_resp) begin
      r_plru[set_idx] <= plru_touch(r_plru[set_idx], w_hit_idx);
    end else if (w_last_beat) begin
      r_plru[r_miss_set] <= plru_touch(r_plru[r_miss_set], r_victim);
    end else if (r_state == S_FLUSH) begin
      r_plru[r_fcnt] <= '0;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Free-running hit/miss counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (mem_resp)    r_hit_count  <= r_hit_count + 32'd1;
      if (w_go_refill) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_nway_control.sv
// tb/tb_icache_nway_control.sv - directed self-checking bench for icache_nway_control (4 ways, 16 sets, 4 beats)
module tb_icache_nway_control;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic [3:0]  set_idx;
  logic [3:0]  hit_way;
  logic [3:0]  valid_way;
  logic        flush;
  logic        pmem_resp;
  logic        mem_resp;
  logic        pmem_read;
  logic        addr_mux_sel;
  logic [3:0]  load_way;
  logic [1:0]  beat_idx;
  logic        valid_in;
  logic        inval;
  logic [3:0]  inval_set;
  logic        flush_busy;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  icache_nway_control #(.NUM_WAYS(4), .NUM_SETS(16), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .set_idx(set_idx), .hit_way(hit_way),
    .valid_way(valid_way), .flush(flush), .pmem_resp(pmem_resp), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .addr_mux_sel(addr_mux_sel), .load_way(load_way),
    .beat_idx(beat_idx), .valid_in(valid_in), .inval(inval), .inval_set(inval_set),
    .flush_busy(flush_busy), .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Miss on a set, run a full 4-beat refill (optional one-cycle stall before beat stall_at), then re-lookup hit.
  task automatic miss_fill(input string tag, input logic [3:0] set, input logic [3:0] valid,
                           input logic [3:0] exp_way, input int stall_at);
    @(negedge clk);
    mem_read = 1'b1; set_idx = set; hit_way = 4'b0000; valid_way = valid; pmem_resp = 1'b0;
    #1 chk($sformatf("%s_miss_no_resp", tag), mem_resp, 0);
    chk($sformatf("%s_miss_no_pmem", tag), pmem_read, 0);
    @(negedge clk);
    #1 chk($sformatf("%s_pmem_read", tag), pmem_read, 1);
    chk($sformatf("%s_addr_mux", tag), addr_mux_sel, 1);
    for (int b = 0; b < 4; b++) begin
      if (b == stall_at) begin
        @(negedge clk); pmem_resp = 1'b0;
        #1 chk($sformatf("%s_stall_load", tag), load_way, 0);
        chk($sformatf("%s_stall_pmem", tag), pmem_read, 1);
      end
      @(negedge clk); pmem_resp = 1'b1;
      #1 chk($sformatf("%s_load_way_b%0d", tag, b), load_way, exp_way);
      chk($sformatf("%s_beat_idx_b%0d", tag, b), beat_idx, b);
      chk($sformatf("%s_valid_in_b%0d", tag, b), valid_in, (b == 3));
    end
    @(negedge clk);
    pmem_resp = 1'b0; hit_way = exp_way; valid_way = valid | exp_way;
    #1 chk($sformatf("%s_refetch_hit", tag), mem_resp, 1);
    chk($sformatf("%s_refetch_pmem", tag), pmem_read, 0);
    @(negedge clk);
    mem_read = 1'b0; hit_way = 4'b0000;
  endtask

  initial begin
    rst = 1'b0; mem_read = 1'b0; set_idx = '0; hit_way = '0; valid_way = '0;
    flush = 1'b0; pmem_resp = 1'b0;

    // Reset state
    #6;
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_inval", inval, 0);
    chk("rst_flush_busy", flush_busy, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    @(negedge clk); rst = 1'b1;

    // Async reset mid-burst at beat 2
    @(negedge clk); mem_read = 1'b1; set_idx = 4'd7; valid_way = 4'b0000;
    @(negedge clk); #1 chk("t1_pmem_read", pmem_read, 1);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); pmem_resp = 1'b1;
    end
    @(negedge clk); pmem_resp = 1'b1;
    #1 chk("t1_beat2_idx", beat_idx, 2);
    rst = 1'b0;
    #1 chk("t1_rst_pmem_drop", pmem_read, 0);
    chk("t1_rst_load_way", load_way, 0);
    chk("t1_rst_addr_mux", addr_mux_sel, 0);
    @(negedge clk); pmem_resp = 1'b0; mem_read = 1'b0; rst = 1'b1;
    miss_fill("t1_after_rst", 4'd7, 4'b0000, 4'b0001, -1);

    // Cold miss on set 3 with an arbiter stall before beat 2
    miss_fill("t2_cold", 4'd3, 4'b0000, 4'b0001, 2);

    // PLRU on set 5, all ways valid
    @(negedge clk); mem_read = 1'b1; set_idx = 4'd5; hit_way = 4'b0001; valid_way = 4'b1111;
    #1 chk("t3_hit_way0", mem_resp, 1);
    @(negedge clk); mem_read = 1'b0; hit_way = 4'b0000;
    miss_fill("t3_vict_w2", 4'd5, 4'b1111, 4'b0100, -1);
    miss_fill("t3_vict_w1", 4'd5, 4'b1111, 4'b0010, -1);
    miss_fill("t3_vict_w3", 4'd5, 4'b1111, 4'b1000, -1);

    // Flush coincident with a hit; a second flush pulse mid-sequence is ignored
    @(negedge clk); mem_read = 1'b1; set_idx = 4'd5; hit_way = 4'b0001; valid_way = 4'b1111; flush = 1'b1;
    #1 chk("t4_flush_beats_hit", mem_resp, 0);
    @(negedge clk); flush = 1'b0;
    for (int i = 0; i < 16; i++) begin
      flush = 1'b0;
      #1 chk($sformatf("t4_inval_%0d", i), inval, 1);
      chk($sformatf("t4_inval_set_%0d", i), inval_set, i);
      chk($sformatf("t4_no_resp_%0d", i), mem_resp, 0);
      if (i == 5) flush = 1'b1;
      @(negedge clk);
    end
    flush = 1'b0;
    #1 chk("t4_flush_over", inval, 0);
    chk("t4_post_flush_hit", mem_resp, 1);
    @(negedge clk); mem_read = 1'b0; hit_way = 4'b0000;

    // Flush pulse during refill beat 1: burst completes, then flush runs
    @(negedge clk); mem_read = 1'b1; set_idx = 4'd9; valid_way = 4'b0000;
    @(negedge clk); #1 chk("t5_pmem_read", pmem_read, 1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); pmem_resp = 1'b1; flush = (b == 1);
      #1 chk($sformatf("t5_load_way_b%0d", b), load_way, 4'b0001);
      chk($sformatf("t5_beat_idx_b%0d", b), beat_idx, b);
      chk($sformatf("t5_busy_b%0d", b), flush_busy, 0);
    end
    @(negedge clk); pmem_resp = 1'b0; flush = 1'b0; mem_read = 1'b0;
    #1 chk("t5_check_pmem", pmem_read, 0);
    chk("t5_check_no_busy", flush_busy, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1 chk($sformatf("t5_busy_%0d", i), flush_busy, 1);
      chk($sformatf("t5_inval_set_%0d", i), inval_set, i);
    end
    @(negedge clk);
    #1 chk("t5_busy_done", flush_busy, 0);

    // Performance counters: fresh reset, 3 hits then 2 miss/refill/hit sequences
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk); mem_read = 1'b1; set_idx = 4'd1; hit_way = 4'b0010; valid_way = 4'b0010;
      @(negedge clk); mem_read = 1'b0; hit_way = 4'b0000;
    end
    miss_fill("t6_m0", 4'd2, 4'b0000, 4'b0001, -1);
    miss_fill("t6_m1", 4'd4, 4'b0000, 4'b0001, -1);
    #1;
`ifdef ICACHE_PERF_CNT_EN
    chk("t6_hit_count", hit_count, 5);
    chk("t6_miss_count", miss_count, 2);
`else
    chk("t6_hit_count_tied", hit_count, 0);
    chk("t6_miss_count_tied", miss_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
